// File: rtl/kd_tree_pkg.sv
// Shared types and sizes for the KD-tree traversal engine.
// A node word is {signed median, split dimension}; a query patch holds five
// signed 11-bit components, component i at bits [11i+10:11i].
package kd_tree_pkg;

    localparam int unsigned DIM_W          = 11;
    localparam int unsigned NUM_DIMS       = 5;
    localparam int unsigned TREE_DEPTH     = 6;
    localparam int unsigned NUM_NODES      = 63;
    localparam int unsigned INTERNAL_WIDTH = 22;
    localparam int unsigned PATCH_WIDTH    = 55;
    localparam int unsigned ADDRESS_WIDTH  = 8;
    // Offset of a node within its level; six bits once the last level is passed.
    localparam int unsigned OFF_W          = 6;
    // Write counter / node address width (0..63).
    localparam int unsigned CNT_W          = 6;

    typedef struct packed {
        logic signed [DIM_W-1:0] median;
        logic        [DIM_W-1:0] dim;
    } node_t;

    typedef logic [NUM_DIMS-1:0][DIM_W-1:0] patch_t;

    // Pick the patch component named by a node's dim field; out-of-range dims use component 0.
    function automatic logic [DIM_W-1:0] select_comp(input patch_t p, input logic [DIM_W-1:0] dim);
        logic [DIM_W-1:0] c;
        case (dim)
            DIM_W'(1): c = p[1];
            DIM_W'(2): c = p[2];
            DIM_W'(3): c = p[3];
            DIM_W'(4): c = p[4];
            default:   c = p[0];
        endcase
        return c;
    endfunction

endpackage

// File: rtl/kd_tree_level.sv
// One traversal stage of the KD tree.
// Selects the node of level LEVEL addressed by the incoming offset, compares the
// chosen patch component against the node median and registers the child offset.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   nodes              shared node store (all 63 nodes, breadth-first)
//   in_valid/in_patch/in_off   query entering this level
//   out_valid/out_off  registered query state for the next level
module kd_tree_level
    import kd_tree_pkg::*;
#(
    parameter int unsigned LEVEL = 0
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  node_t             nodes [NUM_NODES],
    input  logic              in_valid,
    input  patch_t            in_patch,
    input  logic [OFF_W-1:0]  in_off,
    output logic              out_valid,
    output logic [OFF_W-1:0]  out_off
);

    // Breadth-first index of the first node on this level.
    localparam int unsigned BASE = (1 << LEVEL) - 1;

    node_t                    node_c;
    logic signed [DIM_W-1:0]  comp_c;
    logic                     go_right_c;

    // Node select and signed compare; ties go right.
    always_comb begin
        node_c     = nodes[CNT_W'(BASE) + in_off];
        comp_c     = select_comp(in_patch, node_c.dim);
        go_right_c = (comp_c >= node_c.median);
    end

    // Child offset on the next level is 2*offset + direction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_off   <= '0;
        end else begin
            out_valid <= in_valid;
            out_off   <= {in_off[OFF_W-2:0], go_right_c};
        end
    end

endmodule

// File: rtl/kd_internal_node_tree.sv
// Pipelined KD-tree traversal engine: 63 internal nodes (6 levels) loaded
// breadth-first from the aggregator, two independent query ports mapping
// 5-D patches to leaf indices 0..63.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   fsm_enable                      load phase; node writes accepted only while high
//   sender_enable, sender_data      node word stream {median, dim}
//   patch_en/patch_in               query port 1
//   patch_two_en/patch_in_two       query port 2
//   leaf_index/receiver_en          result and 1-cycle strobe, port 1
//   leaf_index_two/receiver_two_en  result and 1-cycle strobe, port 2
// Configuration:
//   KD_TREE_INPUT_REG_EN  register query inputs on entry (latency 7 instead of 6)
module kd_internal_node_tree
    import kd_tree_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      fsm_enable,
    input  logic                      sender_enable,
    input  logic [INTERNAL_WIDTH-1:0] sender_data,
    input  logic                      patch_en,
    input  logic                      patch_two_en,
    input  logic [PATCH_WIDTH-1:0]    patch_in,
    input  logic [PATCH_WIDTH-1:0]    patch_in_two,
    output logic [ADDRESS_WIDTH-1:0]  leaf_index,
    output logic [ADDRESS_WIDTH-1:0]  leaf_index_two,
    output logic                      receiver_en,
    output logic                      receiver_two_en
);

    node_t             nodes [NUM_NODES];
    logic [CNT_W-1:0]  wr_cnt;
    logic              wr_en_c;

    // Writes stop once all 63 nodes are in; only reset reopens the store.
    assign wr_en_c = fsm_enable && sender_enable && (wr_cnt != CNT_W'(NUM_NODES));

    // Node store and write counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt <= '0;
            for (int i = 0; i < NUM_NODES; i++) begin
                nodes[i] <= '0;
            end
        end else if (wr_en_c) begin
            nodes[wr_cnt] <= sender_data;
            wr_cnt        <= wr_cnt + CNT_W'(1);
        end
    end

    logic [1:0] q_v;
    patch_t     q_patch [2];

`ifdef KD_TREE_INPUT_REG_EN
    // Query entry registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_v        <= '0;
            q_patch[0] <= '0;
            q_patch[1] <= '0;
        end else begin
            q_v        <= {patch_two_en, patch_en};
            q_patch[0] <= patch_in;
            q_patch[1] <= patch_in_two;
        end
    end
`else
    // Level 0 compares directly on the port inputs.
    always_comb begin
        q_v        = {patch_two_en, patch_en};
        q_patch[0] = patch_in;
        q_patch[1] = patch_in_two;
    end
`endif

    // One six-level pipeline per query port, both reading the shared node store.
    for (genvar p = 0; p < 2; p++) begin : g_port
        logic              v   [TREE_DEPTH+1];
        logic [OFF_W-1:0]  off [TREE_DEPTH+1];
        patch_t            stage_patch [TREE_DEPTH];
        patch_t            pt_q [TREE_DEPTH-1];
        logic              res_v;
        logic [ADDRESS_WIDTH-1:0] res_idx;

        assign v[0]   = q_v[p];
        assign off[0] = '0;

        // Patch travels alongside the level offset.
        always_comb begin
            stage_patch[0] = q_patch[p];
            for (int i = 1; i < TREE_DEPTH; i++) begin
                stage_patch[i] = pt_q[i-1];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < TREE_DEPTH - 1; i++) begin
                    pt_q[i] <= '0;
                end
            end else begin
                pt_q[0] <= q_patch[p];
                for (int i = 1; i < TREE_DEPTH - 1; i++) begin
                    pt_q[i] <= pt_q[i-1];
                end
            end
        end

        for (genvar l = 0; l < TREE_DEPTH; l++) begin : g_lvl
            kd_tree_level #(.LEVEL(l)) u_level (
                .clk       (clk),
                .rst_n     (rst_n),
                .nodes     (nodes),
                .in_valid  (v[l]),
                .in_patch  (stage_patch[l]),
                .in_off    (off[l]),
                .out_valid (v[l+1]),
                .out_off   (off[l+1])
            );
        end

        // Offset within level 6 is the leaf index; held until the next result.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                res_v   <= 1'b0;
                res_idx <= '0;
            end else begin
                res_v <= v[TREE_DEPTH];
                if (v[TREE_DEPTH]) begin
                    res_idx <= ADDRESS_WIDTH'(off[TREE_DEPTH]);
                end
            end
        end
    end

    assign leaf_index      = g_port[0].res_idx;
    assign receiver_en     = g_port[0].res_v;
    assign leaf_index_two  = g_port[1].res_idx;
    assign receiver_two_en = g_port[1].res_v;

endmodule

// File: tb/tb_kd_internal_node_tree.sv
// Self-checking bench for kd_internal_node_tree: directed and random queries
// checked against a breadth-first tree-walk model of the node store.
module tb_kd_internal_node_tree;

`ifdef KD_TREE_INPUT_REG_EN
    localparam int LAT = 7;
`else
    localparam int LAT = 6;
`endif

    logic        clk;
    logic        rst_n;
    logic        fsm_enable;
    logic        sender_enable;
    logic [21:0] sender_data;
    logic        patch_en;
    logic        patch_two_en;
    logic [54:0] patch_in;
    logic [54:0] patch_in_two;
    logic [7:0]  leaf_index;
    logic [7:0]  leaf_index_two;
    logic        receiver_en;
    logic        receiver_two_en;

    kd_internal_node_tree dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .fsm_enable      (fsm_enable),
        .sender_enable   (sender_enable),
        .sender_data     (sender_data),
        .patch_en        (patch_en),
        .patch_two_en    (patch_two_en),
        .patch_in        (patch_in),
        .patch_in_two    (patch_in_two),
        .leaf_index      (leaf_index),
        .leaf_index_two  (leaf_index_two),
        .receiver_en     (receiver_en),
        .receiver_two_en (receiver_two_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference tree: node n has children 2n+1 / 2n+2, leaves are nodes 63..126.
    int m_med [63];
    int m_dim [63];
    int m_cnt;

    typedef struct {
        bit          en1;
        logic [54:0] p1;
        bit          en2;
        logic [54:0] p2;
    } beat_t;

    beat_t beats [$];
    int exp_edge [2][$];
    int exp_leaf [2][$];
    int got_edge [2][$];
    int got_leaf [2][$];

    function automatic void model_clear();
        for (int i = 0; i < 63; i++) begin
            m_med[i] = 0;
            m_dim[i] = 0;
        end
        m_cnt = 0;
    endfunction

    function automatic int model_leaf(input logic [54:0] p);
        int n = 0;
        int d;
        int c;
        logic signed [10:0] cs;
        for (int lvl = 0; lvl < 6; lvl++) begin
            d  = (m_dim[n] >= 5) ? 0 : m_dim[n];
            cs = p[11*d +: 11];
            c  = cs;
            n  = (c < m_med[n]) ? 2*n + 1 : 2*n + 2;
        end
        return n - 63;
    endfunction

    function automatic logic [54:0] mk_patch(input int c0, input int c2);
        logic [63:0] r;
        logic [54:0] p;
        r = {$urandom(), $urandom()};
        p = r[54:0];
        p[10:0]  = 11'(c0);
        p[32:22] = 11'(c2);
        return p;
    endfunction

    task automatic add_beat(input bit en1, input logic [54:0] p1, input bit en2, input logic [54:0] p2);
        beat_t b;
        b.en1 = en1; b.p1 = p1; b.en2 = en2; b.p2 = p2;
        beats.push_back(b);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic load_node(input int med, input int dim, input bit fen);
        fsm_enable    = fen;
        sender_enable = 1'b1;
        sender_data   = {11'(med), 11'(dim)};
        @(posedge clk);
        #1;
        sender_enable = 1'b0;
        fsm_enable    = 1'b0;
        if (fen && m_cnt < 63) begin
            m_med[m_cnt] = med;
            m_dim[m_cnt] = dim;
            m_cnt++;
        end
    endtask

    // Drive the queued beats, then idle; record every strobe with its edge number.
    task automatic run_batch(input int tail);
        int total;
        total = beats.size() + tail;
        for (int p = 0; p < 2; p++) begin
            exp_edge[p].delete(); exp_leaf[p].delete();
            got_edge[p].delete(); got_leaf[p].delete();
        end
        for (int k = 0; k < total; k++) begin
            if (k < beats.size()) begin
                patch_en     = beats[k].en1;
                patch_in     = beats[k].p1;
                patch_two_en = beats[k].en2;
                patch_in_two = beats[k].p2;
                if (beats[k].en1) begin
                    exp_edge[0].push_back(k + LAT);
                    exp_leaf[0].push_back(model_leaf(beats[k].p1));
                end
                if (beats[k].en2) begin
                    exp_edge[1].push_back(k + LAT);
                    exp_leaf[1].push_back(model_leaf(beats[k].p2));
                end
            end else begin
                patch_en     = 1'b0;
                patch_two_en = 1'b0;
            end
            @(posedge clk);
            #1;
            if (receiver_en === 1'b1) begin
                got_edge[0].push_back(k);
                got_leaf[0].push_back(int'(leaf_index));
            end
            if (receiver_two_en === 1'b1) begin
                got_edge[1].push_back(k);
                got_leaf[1].push_back(int'(leaf_index_two));
            end
        end
        patch_en     = 1'b0;
        patch_two_en = 1'b0;
        beats.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; fsm_enable = 1'b0; sender_enable = 1'b0; sender_data = '0;
        patch_en = 1'b0; patch_two_en = 1'b0; patch_in = '0; patch_in_two = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (leaf_index !== 8'd0) begin errors++; $display("FAIL reset leaf_index got %0h want 0", leaf_index); end
        checks++; if (leaf_index_two !== 8'd0) begin errors++; $display("FAIL reset leaf_index_two got %0h want 0", leaf_index_two); end
        checks++; if (receiver_en !== 1'b0) begin errors++; $display("FAIL reset receiver_en got %b want 0", receiver_en); end
        checks++; if (receiver_two_en !== 1'b0) begin errors++; $display("FAIL reset receiver_two_en got %b want 0", receiver_two_en); end
        rst_n = 1'b1;
    endtask

    task automatic test_zero_tree();
        do_reset();
        for (int i = 0; i < 63; i++) load_node(0, 0, 1'b1);
        add_beat(1'b1, mk_patch(5, 0), 1'b1, mk_patch(-5, 0));
        add_beat(1'b1, mk_patch(0, 0), 1'b1, mk_patch(0, 7));
        run_batch(LAT + 3);
        for (int p = 0; p < 2; p++) begin
            checks++;
            if (got_edge[p].size() != exp_edge[p].size()) begin
                errors++; $display("FAIL zero_tree count port%0d got %0d want %0d", p+1, got_edge[p].size(), exp_edge[p].size());
            end
            for (int i = 0; i < got_edge[p].size() && i < exp_edge[p].size(); i++) begin
                checks++;
                if (got_leaf[p][i] != exp_leaf[p][i] || got_edge[p][i] != exp_edge[p][i]) begin
                    errors++; $display("FAIL zero_tree port%0d #%0d got leaf %0d edge %0d want leaf %0d edge %0d",
                                       p+1, i, got_leaf[p][i], got_edge[p][i], exp_leaf[p][i], exp_edge[p][i]);
                end
            end
        end
    endtask

    task automatic test_root_split();
        do_reset();
        load_node(100, 2, 1'b1);
        for (int i = 1; i < 63; i++) load_node(0, 0, 1'b1);
        add_beat(1'b1, mk_patch(1, 99), 1'b1, mk_patch(-1, 100));
        run_batch(LAT + 3);
        for (int p = 0; p < 2; p++) begin
            checks++;
            if (got_edge[p].size() != exp_edge[p].size()) begin
                errors++; $display("FAIL root_split count port%0d got %0d want %0d", p+1, got_edge[p].size(), exp_edge[p].size());
            end
            for (int i = 0; i < got_edge[p].size() && i < exp_edge[p].size(); i++) begin
                checks++;
                if (got_leaf[p][i] != exp_leaf[p][i] || got_edge[p][i] != exp_edge[p][i]) begin
                    errors++; $display("FAIL root_split port%0d #%0d got leaf %0d edge %0d want leaf %0d edge %0d",
                                       p+1, i, got_leaf[p][i], got_edge[p][i], exp_leaf[p][i], exp_edge[p][i]);
                end
            end
        end
    endtask

    // Uses the root-split tree left by the previous test.
    task automatic test_back_to_back();
        add_beat(1'b1, mk_patch(-1, 50), 1'b0, '0);
        add_beat(1'b1, mk_patch(5, 100), 1'b0, '0);
        add_beat(1'b1, mk_patch(1, 99), 1'b0, '0);
        run_batch(LAT + 4);
        checks++;
        if (got_edge[0].size() != exp_edge[0].size()) begin
            errors++; $display("FAIL back_to_back count got %0d want %0d", got_edge[0].size(), exp_edge[0].size());
        end
        for (int i = 0; i < got_edge[0].size() && i < exp_edge[0].size(); i++) begin
            checks++;
            if (got_leaf[0][i] != exp_leaf[0][i] || got_edge[0][i] != exp_edge[0][i]) begin
                errors++; $display("FAIL back_to_back #%0d got leaf %0d edge %0d want leaf %0d edge %0d",
                                   i, got_leaf[0][i], got_edge[0][i], exp_leaf[0][i], exp_edge[0][i]);
            end
        end
        checks++;
        if (int'(leaf_index) != exp_leaf[0][2]) begin
            errors++; $display("FAIL back_to_back hold got %0d want %0d", leaf_index, exp_leaf[0][2]);
        end
        checks++;
        if (got_edge[1].size() != 0) begin
            errors++; $display("FAIL back_to_back idle port2 strobes got %0d want 0", got_edge[1].size());
        end
    endtask

    task automatic test_load_limits();
        do_reset();
        // Writes without fsm_enable must not land or advance the counter.
        load_node(100, 0, 1'b0);
        load_node(-300, 1, 1'b0);
        fsm_enable = 1'b1; sender_enable = 1'b0; sender_data = {11'(100), 11'(0)};
        @(posedge clk); #1 fsm_enable = 1'b0;
        for (int i = 0; i < 62; i++) load_node(0, 0, 1'b1);
        load_node(10, 0, 1'b1);
        // 64th write is past the end of the store.
        load_node(-1000, 0, 1'b1);
        load_node(-1000, 0, 1'b0);
        add_beat(1'b1, mk_patch(5, 0), 1'b1, mk_patch(20, 0));
        add_beat(1'b1, mk_patch(-3, 0), 1'b1, mk_patch(10, 0));
        run_batch(LAT + 3);
        for (int p = 0; p < 2; p++) begin
            checks++;
            if (got_edge[p].size() != exp_edge[p].size()) begin
                errors++; $display("FAIL load_limits count port%0d got %0d want %0d", p+1, got_edge[p].size(), exp_edge[p].size());
            end
            for (int i = 0; i < got_edge[p].size() && i < exp_edge[p].size(); i++) begin
                checks++;
                if (got_leaf[p][i] != exp_leaf[p][i] || got_edge[p][i] != exp_edge[p][i]) begin
                    errors++; $display("FAIL load_limits port%0d #%0d got leaf %0d edge %0d want leaf %0d edge %0d",
                                       p+1, i, got_leaf[p][i], got_edge[p][i], exp_leaf[p][i], exp_edge[p][i]);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [63:0] r1;
        logic [63:0] r2;
        do_reset();
        for (int i = 0; i < 63; i++) begin
            load_node(int'($urandom_range(0, 2047)) - 1024, int'($urandom_range(0, 7)), 1'b1);
        end
        for (int k = 0; k < 40; k++) begin
            r1 = {$urandom(), $urandom()};
            r2 = {$urandom(), $urandom()};
            add_beat($urandom_range(0, 3) != 0, r1[54:0], $urandom_range(0, 3) != 0, r2[54:0]);
        end
        run_batch(LAT + 3);
        for (int p = 0; p < 2; p++) begin
            checks++;
            if (got_edge[p].size() != exp_edge[p].size()) begin
                errors++; $display("FAIL random count port%0d got %0d want %0d", p+1, got_edge[p].size(), exp_edge[p].size());
            end
            for (int i = 0; i < got_edge[p].size() && i < exp_edge[p].size(); i++) begin
                checks++;
                if (got_leaf[p][i] != exp_leaf[p][i] || got_edge[p][i] != exp_edge[p][i]) begin
                    errors++; $display("FAIL random port%0d #%0d got leaf %0d edge %0d want leaf %0d edge %0d",
                                       p+1, i, got_leaf[p][i], got_edge[p][i], exp_leaf[p][i], exp_edge[p][i]);
                end
            end
        end
    endtask

    task automatic test_reset_in_flight();
        int seen;
        for (int k = 0; k < 3; k++) begin
            patch_en = 1'b1; patch_in = mk_patch(7, 7);
            patch_two_en = 1'b1; patch_in_two = mk_patch(-7, 3);
            @(posedge clk); #1;
        end
        patch_en = 1'b0; patch_two_en = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        model_clear();
        #1;
        checks++; if (leaf_index !== 8'd0) begin errors++; $display("FAIL midreset leaf_index got %0h want 0", leaf_index); end
        checks++; if (leaf_index_two !== 8'd0) begin errors++; $display("FAIL midreset leaf_index_two got %0h want 0", leaf_index_two); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (receiver_en !== 1'b0 || receiver_two_en !== 1'b0) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL midreset strobes got %0d want 0", seen); end
        // A fresh write must land at node 0 after reset.
        load_node(100, 0, 1'b1);
        add_beat(1'b1, mk_patch(50, 0), 1'b1, mk_patch(150, 0));
        run_batch(LAT + 3);
        for (int p = 0; p < 2; p++) begin
            checks++;
            if (got_edge[p].size() != exp_edge[p].size()) begin
                errors++; $display("FAIL midreset count port%0d got %0d want %0d", p+1, got_edge[p].size(), exp_edge[p].size());
            end
            for (int i = 0; i < got_edge[p].size() && i < exp_edge[p].size(); i++) begin
                checks++;
                if (got_leaf[p][i] != exp_leaf[p][i] || got_edge[p][i] != exp_edge[p][i]) begin
                    errors++; $display("FAIL midreset port%0d #%0d got leaf %0d edge %0d want leaf %0d edge %0d",
                                       p+1, i, got_leaf[p][i], got_edge[p][i], exp_leaf[p][i], exp_edge[p][i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_tree();
        test_root_split();
        test_back_to_back();
        test_load_limits();
        test_random();
        test_reset_in_flight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
